// File: rtl/uart_tx.sv
// UART transmit engine: byte FIFO feeding an 8N1/8E1/8O1/8N2 serialiser with a
// programmable bit period. All outputs are registered.
module uart_tx #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic [31:0]                   divider_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          stop2_i,
  input  logic [7:0]                    tx_d_i,
  input  logic                          tx_d_valid_i,
  input  logic                          ovf_clr_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          fifo_empty_o,
  output logic                          fifo_full_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic                          done_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic [2:0]  state;
  logic [31:0] cnt;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic [7:0]  data;
  logic [31:0] d_lat;
  logic        pe_lat, po_lat, s2_lat;

  logic [2:0]  nxt_state;
  logic [31:0] nxt_cnt;
  logic [2:0]  nxt_bit;
  logic        nxt_stop;
  logic [7:0]  nxt_data;
  logic [31:0] nxt_d;
  logic        nxt_pe, nxt_po, nxt_s2;
  logic        nxt_tx, nxt_done;
  logic [LW-1:0] nxt_level;

  logic bit_end, last_stop, pop, push_ok;

  // d_lat is never 0 outside IDLE, so cnt always has a reachable terminal value.
  assign bit_end   = (state != S_IDLE) && (cnt == d_lat - 32'd1);
  assign last_stop = (state == S_STOP) && (stop_idx == s2_lat);
  assign pop       = enable_i && (fifo_level_o != '0) &&
                     ((state == S_IDLE) || (last_stop && bit_end));
  assign push_ok   = tx_d_valid_i && ((fifo_level_o != DEPTH_L) || pop);
  assign nxt_level = fifo_level_o + {{(LW-1){1'b0}}, push_ok}
                                  - {{(LW-1){1'b0}}, pop};

  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_bit   = bit_idx;
    nxt_stop  = stop_idx;
    nxt_data  = data;
    nxt_d     = d_lat;
    nxt_pe    = pe_lat;
    nxt_po    = po_lat;
    nxt_s2    = s2_lat;
    if (pop) begin
      // Frame start (also back-to-back from the last stop bit).
      nxt_state = S_START;
      nxt_cnt   = '0;
      nxt_data  = mem[rd_ptr];
      nxt_d     = (divider_i == '0) ? 32'd1 : divider_i;
      nxt_pe    = parity_en_i;
      nxt_po    = parity_odd_i;
      nxt_s2    = stop2_i;
    end else if (state != S_IDLE) begin
      if (bit_end) begin
        nxt_cnt = '0;
        case (state)
          S_START: begin
            nxt_state = S_DATA;
            nxt_bit   = '0;
          end
          S_DATA: begin
            if (bit_idx == 3'd7) begin
              nxt_state = pe_lat ? S_PARITY : S_STOP;
              nxt_stop  = 1'b0;
            end else begin
              nxt_bit = bit_idx + 3'd1;
            end
          end
          S_PARITY: begin
            nxt_state = S_STOP;
            nxt_stop  = 1'b0;
          end
          S_STOP: begin
            if (last_stop) nxt_state = S_IDLE;
            else           nxt_stop  = 1'b1;
          end
          default: nxt_state = S_IDLE;
        endcase
      end else begin
        nxt_cnt = cnt + 32'd1;
      end
    end

    case (nxt_state)
      S_START:  nxt_tx = 1'b0;
      S_DATA:   nxt_tx = nxt_data[nxt_bit];
      S_PARITY: nxt_tx = (^nxt_data) ^ nxt_po;
      default:  nxt_tx = 1'b1;
    endcase
    // done_o is registered, so flag the cycle that will be the final stop cycle.
    nxt_done = (nxt_state == S_STOP) && (nxt_stop == nxt_s2) &&
               (nxt_cnt == nxt_d - 32'd1);
  end

  // NOTE: FIFO storage has no reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= tx_d_i;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      data         <= '0;
      d_lat        <= 32'd1;
      pe_lat       <= 1'b0;
      po_lat       <= 1'b0;
      s2_lat       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level_o <= '0;
      fifo_empty_o <= 1'b1;
      fifo_full_o  <= 1'b0;
      overflow_o   <= 1'b0;
      tx_o         <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      bit_idx      <= nxt_bit;
      stop_idx     <= nxt_stop;
      data         <= nxt_data;
      d_lat        <= nxt_d;
      pe_lat       <= nxt_pe;
      po_lat       <= nxt_po;
      s2_lat       <= nxt_s2;
      wr_ptr       <= wr_ptr + {{(AW-1){1'b0}}, push_ok};
      rd_ptr       <= rd_ptr + {{(AW-1){1'b0}}, pop};
      fifo_level_o <= nxt_level;
      fifo_empty_o <= (nxt_level == '0);
      fifo_full_o  <= (nxt_level == DEPTH_L);
      // A dropped write takes priority over a clear in the same cycle.
      if (tx_d_valid_i && !push_ok) overflow_o <= 1'b1;
      else if (ovf_clr_i)           overflow_o <= 1'b0;
      tx_o         <= nxt_tx;
      busy_o       <= (nxt_state != S_IDLE);
      done_o       <= nxt_done;
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmit engine that serialises bytes written to the UART register block's TXDATA register onto the serial line.
- Consumes the register block's TX interface: `tx_d`, `tx_d_valid`, `tx_enable`, `divider`.
- Buffers bytes in a small FIFO and emits 8N1/8E1/8O1/8N2 frames at a programmable bit period.
- Reports status flags back for the TXSTATUS register and for the interrupt logic.

## Interface
Parameters:
- FIFO_DEPTH, 8, number of byte entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous and active-high; sampled only on the rising edge of clk.
- enable_i  in  1  transmitter enable, from the register block's tx_enable.
- divider_i  in  32  bit period in clk cycles; 0 is treated as 1.
- parity_en_i  in  1  when 1, a parity bit is inserted after the data bits.
- parity_odd_i  in  1  parity sense: 1 = odd, 0 = even.
- stop2_i  in  1  when 1, two stop bits are sent; when 0, one.
- tx_d_i  in  8  byte to enqueue.
- tx_d_valid_i  in  1  one-cycle write strobe; there is no ready signal.
- ovf_clr_i  in  1  clears the sticky overflow flag.
- tx_o  out  1  serial line; idles high.
- busy_o  out  1  a frame is in progress.
- fifo_empty_o  out  1  FIFO holds 0 entries.
- fifo_full_o  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current entry count.
- overflow_o  out  1  sticky: a write was dropped.
- done_o  out  1  one-cycle pulse at the end of the last stop bit.

## Operation
Reset values (all outputs registered):
- tx_o=1, busy_o=0, fifo_empty_o=1, fifo_full_o=0, fifo_level_o=0, overflow_o=0, done_o=0.
- FIFO pointers cleared; state machine in IDLE.

FIFO push:
- A write is accepted when tx_d_valid_i=1 and either level<FIFO_DEPTH or a pop occurs in the same cycle.
- Otherwise the byte is dropped and overflow_o is set.
- Simultaneous push and pop leaves the level unchanged.
- Pushes are accepted regardless of enable_i.
- Pointers wrap modulo FIFO_DEPTH.

Overflow flag:
- ovf_clr_i clears overflow_o.
- If a set and a clear occur in the same cycle, set wins.

State machine: IDLE, START, DATA, PARITY, STOP.
- IDLE → START: when enable_i=1 and the FIFO is not empty. This pops one byte into the shift register and latches divider_i, parity_en_i, parity_odd_i and stop2_i into frame-local registers.
- START: tx_o=0 for one bit period.
- DATA: 8 bits, LSB first, one bit period each; a 3-bit counter selects the bit.
- PARITY: entered only if the latched parity_en=1. tx_o = XOR of the data bits, inverted if parity_odd=1.
- STOP: tx_o=1 for 1 or 2 bit periods. At the end, done_o pulses for one cycle and the FSM returns to IDLE.
- Back-to-back frames: if the FIFO is non-empty and enable_i=1 at the end of STOP, the FSM goes directly to START with no idle gap.

Bit timing:
- The baud counter counts 0 .. max(latched divider,1)-1.
- A bit ends when the counter reaches its terminal value; the counter then resets.

enable_i deasserted mid-frame:
- The current frame completes unchanged.
- No new frame starts until enable_i returns to 1.

Input changes mid-frame:
- Changes to divider_i or the parity/stop inputs affect only the next frame.

busy_o is 1 in every state except IDLE.

## Timing
- Push: a tx_d_valid_i strobe in cycle N is reflected in fifo_level_o and the empty/full flags in cycle N+1.
- Frame start: with the FSM in IDLE, enable_i=1 and the FIFO non-empty at edge N, tx_o goes low and busy_o rises after edge N. fifo_level_o decrements at the same edge.
- Frame length: (1 + 8 + parity_en + 1 + stop2) × D clk cycles, where D = max(divider,1).
- done_o: asserted during the final cycle of the last stop bit.
- Reset mid-frame: on the edge where rst=1, tx_o returns to 1 and the FIFO contents are discarded. No partial bits are emitted after reset.

## Test plan
- Single frame, 8N1: divider=4, push 0xA5, enable=1. tx_o must be low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. busy_o lasts 40 cycles; done_o pulses once.
- Parity and two stop bits: divider=2, push 0xA5 (four ones).
  - Even parity: parity bit 0, frame length 24 cycles with stop2=1.
  - Odd parity: parity bit 1.
- Overflow: FIFO_DEPTH=8, enable=0, push 9 bytes. Expect level=8, full=1, overflow=1; the 9th byte is dropped. Then enable=1: exactly 8 frames, and the FIFO drains to empty.
  - Next, ovf_clr_i together with a push while full: overflow stays 1.
- Back-to-back frames: push 0x00 and 0xFF, divider=1. The second start bit must immediately follow the first frame's stop bit; total 20 cycles busy.
- Enable drop mid-frame: deassert enable during DATA with 2 bytes queued. The first frame completes; the second starts only after re-enable. A divider_i change mid-frame does not alter the current bit period.
- Reset mid-frame: assert rst during DATA. The next cycle must show tx_o=1, level=0, busy_o=0 and overflow_o=0.
